// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: in-flight entry layout, default index
// width and the 2-bit PHT counter encoding used by both the PHT and gshare_ctrl.
package bp_pkg;

  localparam int BP_INDEX_WIDTH = 12;

  typedef logic [BP_INDEX_WIDTH-1:0] bp_index_t;

  // ghr is stored zero-extended to the index width so one entry type fits any
  // history length up to the index width.
  typedef struct packed {
    bp_index_t index;
    bp_index_t ghr;
  } bp_entry_t;

  localparam logic [1:0] PHT_STRONG_NT = 2'b00;
  localparam logic [1:0] PHT_WEAK_NT   = 2'b01;
  localparam logic [1:0] PHT_WEAK_T    = 2'b10;
  localparam logic [1:0] PHT_STRONG_T  = 2'b11;

  // Saturating 2-bit counter step shared with the PHT.
  function automatic logic [1:0] pht_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    case (state)
      PHT_STRONG_NT: nxt = taken ? PHT_WEAK_NT  : PHT_STRONG_NT;
      PHT_WEAK_NT:   nxt = taken ? PHT_WEAK_T   : PHT_STRONG_NT;
      PHT_WEAK_T:    nxt = taken ? PHT_STRONG_T : PHT_WEAK_NT;
      PHT_STRONG_T:  nxt = taken ? PHT_STRONG_T : PHT_WEAK_T;
      default:       nxt = PHT_WEAK_NT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_ctrl_if.sv
// Fetch / resolve / PHT-update signal bundle for gshare_ctrl.
interface gshare_ctrl_if
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = BP_INDEX_WIDTH,
  parameter int DEPTH       = 8
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   fetch_valid_i;
  logic                   fetch_is_br_i;
  logic [31:0]            fetch_pc_i;
  logic                   pred_taken_i;
  logic [INDEX_WIDTH-1:0] rd_index_o;
  logic                   full_o;
  logic                   resolve_valid_i;
  logic                   resolve_taken_i;
  logic                   resolve_mispred_i;
  logic                   flush_i;
  logic                   update_en_o;
  logic [INDEX_WIDTH-1:0] update_index_o;
  logic                   br_taken_o;
  logic [CW-1:0]          count_o;

  modport master (
    output fetch_valid_i, fetch_is_br_i, fetch_pc_i, pred_taken_i,
    output resolve_valid_i, resolve_taken_i, resolve_mispred_i, flush_i,
    input  rd_index_o, full_o, update_en_o, update_index_o, br_taken_o, count_o
  );

  modport slave (
    input  fetch_valid_i, fetch_is_br_i, fetch_pc_i, pred_taken_i,
    input  resolve_valid_i, resolve_taken_i, resolve_mispred_i, flush_i,
    output rd_index_o, full_o, update_en_o, update_index_o, br_taken_o, count_o
  );

endinterface

// File: rtl/br_info_fifo.sv
// In-flight branch FIFO: holds {index, history snapshot} per predicted branch
// in program order; clear wins over push and pop.
module br_info_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  bp_entry_t                din,
  output bp_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bp_entry_t         mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              full_r;
  logic              wr_en_s;
  logic              rd_en_s;

  assign wr_en_s = push & ~full_r & ~clear;
  assign rd_en_s = pop & (count_r != {CW{1'b0}}) & ~clear;

  // Occupancy for the next cycle.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {CW{1'b0}};
    end else if (wr_en_s && !rd_en_s) begin
      count_next_s = count_r + CW'(1);
    end else if (rd_en_s && !wr_en_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, count and full flag; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (clear) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (wr_en_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (rd_en_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
    end
  end

  // Entry storage; contents are only meaningful below count_r.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;

endmodule

// File: rtl/gshare_ctrl.sv
// gshare index generation, speculative/committed global history and PHT
// update sequencing, with history repair on mispredict or flush.
module gshare_ctrl
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = BP_INDEX_WIDTH,
  parameter int HIST_WIDTH  = 12,
  parameter int DEPTH       = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  gshare_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [HIST_WIDTH-1:0]  spec_ghr_r;
  logic [HIST_WIDTH-1:0]  commit_ghr_r;
  logic [HIST_WIDTH-1:0]  spec_ghr_next_s;
  logic [HIST_WIDTH-1:0]  commit_ghr_next_s;
  logic [HIST_WIDTH-1:0]  resolved_hist_s;
  logic [INDEX_WIDTH-1:0] rd_index_s;
  logic                   update_en_r;
  logic [INDEX_WIDTH-1:0] update_index_r;
  logic                   br_taken_r;
  bp_entry_t              head_s;
  bp_entry_t              push_entry_s;
  logic [CW-1:0]          count_s;
  logic                   full_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   mispred_s;
  logic                   clear_s;
  logic                   unused_s;

  function automatic logic [HIST_WIDTH-1:0] shift_hist(input logic [HIST_WIDTH-1:0] h,
                                                       input logic b);
    logic [HIST_WIDTH-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  assign rd_index_s = bus.fetch_pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(spec_ghr_r);

  assign push_s    = bus.fetch_valid_i & bus.fetch_is_br_i & ~full_s;
  assign pop_s     = bus.resolve_valid_i & (count_s != {CW{1'b0}});
  assign mispred_s = pop_s & bus.resolve_mispred_i;
  // Younger entries are wrong-path after a mispredict or flush.
  assign clear_s   = mispred_s | bus.flush_i;

  assign push_entry_s.index = bp_index_t'(rd_index_s);
  assign push_entry_s.ghr   = bp_index_t'(spec_ghr_r);
  assign resolved_hist_s    = shift_hist(head_s.ghr[HIST_WIDTH-1:0], bus.resolve_taken_i);

  br_info_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .clear (clear_s),
    .din   (push_entry_s),
    .head  (head_s),
    .count (count_s),
    .full  (full_s)
  );

  // Next history values; flush restores from the post-pop committed history.
  always_comb begin
    commit_ghr_next_s = commit_ghr_r;
    spec_ghr_next_s   = spec_ghr_r;
    if (pop_s) begin
      commit_ghr_next_s = resolved_hist_s;
    end else begin
      commit_ghr_next_s = commit_ghr_r;
    end
    if (bus.flush_i) begin
      spec_ghr_next_s = commit_ghr_next_s;
    end else if (mispred_s) begin
      spec_ghr_next_s = resolved_hist_s;
    end else if (push_s) begin
      spec_ghr_next_s = shift_hist(spec_ghr_r, bus.pred_taken_i);
    end else begin
      spec_ghr_next_s = spec_ghr_r;
    end
  end

  // History registers and the PHT update port register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_ghr_r     <= {HIST_WIDTH{1'b0}};
      commit_ghr_r   <= {HIST_WIDTH{1'b0}};
      update_en_r    <= 1'b0;
      update_index_r <= {INDEX_WIDTH{1'b0}};
      br_taken_r     <= 1'b0;
    end else begin
      spec_ghr_r   <= spec_ghr_next_s;
      commit_ghr_r <= commit_ghr_next_s;
      update_en_r  <= pop_s;
      if (pop_s) begin
        update_index_r <= head_s.index[INDEX_WIDTH-1:0];
        br_taken_r     <= bus.resolve_taken_i;
      end
    end
  end

  assign bus.rd_index_o     = rd_index_s;
  assign bus.full_o         = full_s;
  assign bus.count_o        = count_s;
  assign bus.update_en_o    = update_en_r;
  assign bus.update_index_o = update_index_r;
  assign bus.br_taken_o     = br_taken_r;

  assign unused_s = ^{bus.fetch_pc_i[31:INDEX_WIDTH+2], bus.fetch_pc_i[1:0], head_s};

endmodule

// File: tb/tb_gshare_ctrl.sv
// Directed self-checking bench for gshare_ctrl with hand-computed expectations.
module tb_gshare_ctrl;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [11:0] mspec;
  logic [11:0] exp_idx;
  logic [31:0] pc_v;
  logic [11:0] q[$];
  logic        pred_v;

  always #5 clk = ~clk;

  gshare_ctrl_if bus ();

  gshare_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid_i     = 1'b0;
    bus.fetch_is_br_i     = 1'b0;
    bus.pred_taken_i      = 1'b0;
    bus.resolve_valid_i   = 1'b0;
    bus.resolve_taken_i   = 1'b0;
    bus.resolve_mispred_i = 1'b0;
    bus.flush_i           = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic pred);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_is_br_i = 1'b1;
    bus.fetch_pc_i    = pc;
    bus.pred_taken_i  = pred;
  endtask

  task automatic resolve(input logic taken, input logic mispred);
    bus.resolve_valid_i   = 1'b1;
    bus.resolve_taken_i   = taken;
    bus.resolve_mispred_i = mispred;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.fetch_pc_i = 32'h0000_0010;
    #12;
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_upd_en", 32'(bus.update_en_o), 32'd0);
    chk("rst_upd_idx", 32'(bus.update_index_o), 32'd0);
    chk("rst_br_taken", 32'(bus.br_taken_o), 32'd0);
    chk("rst_rd_index", 32'(bus.rd_index_o), 32'h004);
    tick();
    rst = 1'b0;

    // First branch and back-to-back history visibility
    fetch(32'h0000_0010, 1'b1);
    #1 chk("first_rd_index", 32'(bus.rd_index_o), 32'h004);
    tick(); idle();
    chk("b2b_rd_index", 32'(bus.rd_index_o), 32'h005);
    chk("b2b_count", 32'(bus.count_o), 32'd1);

    // Fill to full
    for (int i = 0; i < 7; i++) begin
      fetch(32'h0000_0010, 1'b0);
      tick();
    end
    idle();
    chk("full_count", 32'(bus.count_o), 32'd8);
    chk("full_flag", 32'(bus.full_o), 32'd1);
    fetch(32'h0000_0010, 1'b1);
    #1 chk("ninth_rd_index", 32'(bus.rd_index_o), 32'h084);
    tick(); idle();
    chk("ninth_no_hist", 32'(bus.rd_index_o), 32'h084);
    chk("ninth_count", 32'(bus.count_o), 32'd8);

    // Pop at full with a blocked same-cycle push
    fetch(32'h0000_0010, 1'b1);
    resolve(1'b1, 1'b0);
    tick(); idle();
    chk("popfull_count", 32'(bus.count_o), 32'd7);
    chk("popfull_full", 32'(bus.full_o), 32'd0);
    chk("popfull_upd_en", 32'(bus.update_en_o), 32'd1);
    chk("popfull_upd_idx", 32'(bus.update_index_o), 32'h004);
    chk("popfull_taken", 32'(bus.br_taken_o), 32'd1);
    chk("popfull_no_hist", 32'(bus.rd_index_o), 32'h084);
    tick();
    chk("upd_pulse_low", 32'(bus.update_en_o), 32'd0);
    chk("upd_idx_hold", 32'(bus.update_index_o), 32'h004);

    // Flush alone: spec restored from commit (0x001)
    bus.flush_i = 1'b1;
    tick(); idle();
    chk("flush_count", 32'(bus.count_o), 32'd0);
    chk("flush_rd_index", 32'(bus.rd_index_o), 32'h005);

    // Two pushes, resolve the first correctly predicted
    fetch(32'h0000_0010, 1'b1);
    #1 chk("p2a_rd_index", 32'(bus.rd_index_o), 32'h005);
    tick();
    fetch(32'h0000_0010, 1'b0);
    #1 chk("p2b_rd_index", 32'(bus.rd_index_o), 32'h007);
    tick(); idle();
    resolve(1'b1, 1'b0);
    tick(); idle();
    chk("res_upd_en", 32'(bus.update_en_o), 32'd1);
    chk("res_upd_idx", 32'(bus.update_index_o), 32'h005);
    chk("res_taken", 32'(bus.br_taken_o), 32'd1);
    chk("res_count", 32'(bus.count_o), 32'd1);

    // Mispredict with same-cycle fetch: head {idx 0x007, ghr 0x003}
    fetch(32'h0000_0010, 1'b1);
    tick();
    fetch(32'h0000_0010, 1'b1);
    #1 chk("mp_pre_rd_index", 32'(bus.rd_index_o), 32'h009);
    tick(); idle();
    chk("mp_pre_count", 32'(bus.count_o), 32'd3);
    fetch(32'h0000_0010, 1'b1);
    resolve(1'b0, 1'b1);
    tick(); idle();
    chk("mp_count", 32'(bus.count_o), 32'd0);
    chk("mp_upd_en", 32'(bus.update_en_o), 32'd1);
    chk("mp_upd_idx", 32'(bus.update_index_o), 32'h007);
    chk("mp_taken", 32'(bus.br_taken_o), 32'd0);
    chk("mp_rd_index", 32'(bus.rd_index_o), 32'h002);

    // Flush together with a taken resolve: head {idx 0x002, ghr 0x006}
    fetch(32'h0000_0010, 1'b0);
    tick();
    fetch(32'h0000_0010, 1'b0);
    tick(); idle();
    chk("fp_pre_rd_index", 32'(bus.rd_index_o), 32'h01C);
    fetch(32'h0000_0010, 1'b1);
    resolve(1'b1, 1'b0);
    bus.flush_i = 1'b1;
    tick(); idle();
    chk("fp_upd_en", 32'(bus.update_en_o), 32'd1);
    chk("fp_upd_idx", 32'(bus.update_index_o), 32'h002);
    chk("fp_taken", 32'(bus.br_taken_o), 32'd1);
    chk("fp_count", 32'(bus.count_o), 32'd0);
    chk("fp_rd_index", 32'(bus.rd_index_o), 32'h009);
    tick();
    chk("fp_upd_low", 32'(bus.update_en_o), 32'd0);

    // Resolve on empty FIFO is ignored
    resolve(1'b1, 1'b1);
    tick(); idle();
    chk("empty_upd_en", 32'(bus.update_en_o), 32'd0);
    chk("empty_upd_idx", 32'(bus.update_index_o), 32'h002);
    chk("empty_count", 32'(bus.count_o), 32'd0);
    chk("empty_rd_index", 32'(bus.rd_index_o), 32'h009);
    bus.flush_i = 1'b1;
    tick(); idle();
    chk("empty_commit", 32'(bus.rd_index_o), 32'h009);

    // Streaming push+pop through pointer wrap
    mspec = 12'h00D;
    pc_v  = 32'h0000_0010;
    fetch(pc_v, 1'b0);
    exp_idx = pc_v[13:2] ^ mspec;
    #1 chk("wrap_first_rd", 32'(bus.rd_index_o), 32'(exp_idx));
    q.push_back(exp_idx);
    mspec = {mspec[10:0], 1'b0};
    tick(); idle();
    for (int i = 0; i < 10; i++) begin
      pc_v   = 32'h0000_0100 + 32'(i * 20);
      pred_v = (i % 3) == 0;
      fetch(pc_v, pred_v);
      resolve(1'b0, 1'b0);
      exp_idx = pc_v[13:2] ^ mspec;
      #1 chk("wrap_rd_index", 32'(bus.rd_index_o), 32'(exp_idx));
      q.push_back(exp_idx);
      mspec = {mspec[10:0], pred_v};
      tick(); idle();
      chk("wrap_upd_en", 32'(bus.update_en_o), 32'd1);
      chk("wrap_upd_idx", 32'(bus.update_index_o), 32'(q.pop_front()));
      chk("wrap_count", 32'(bus.count_o), 32'd1);
    end

    // Asynchronous reset mid-cycle
    bus.fetch_pc_i = 32'h0000_0010;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count_o), 32'd0);
    chk("arst_full", 32'(bus.full_o), 32'd0);
    chk("arst_upd_en", 32'(bus.update_en_o), 32'd0);
    chk("arst_upd_idx", 32'(bus.update_index_o), 32'd0);
    chk("arst_taken", 32'(bus.br_taken_o), 32'd0);
    chk("arst_rd_index", 32'(bus.rd_index_o), 32'h004);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
